// File: rtl/mux_spike_demux_if.sv
// Spike bus between the shared column, the demux and the downstream layer.
// The master drives column spikes and frame sync; the slave returns replays.
interface mux_spike_demux_if #(
   parameter int Q = 2
);
   logic         frame_sync;
   logic [Q-1:0] col_spikes;
   logic [Q-1:0] output_spikes1;
   logic [Q-1:0] output_spikes2;
   logic         slot;
   logic         frame_valid;
   logic         sync_err;

   modport master (
      output frame_sync,
      output col_spikes,
      input  output_spikes1,
      input  output_spikes2,
      input  slot,
      input  frame_valid,
      input  sync_err
   );

   modport slave (
      input  frame_sync,
      input  col_spikes,
      output output_spikes1,
      output output_spikes2,
      output slot,
      output frame_valid,
      output sync_err
   );
endinterface

// File: rtl/mux_spike_demux.sv
// Splits time-multiplexed column spikes into two networks and replays
// both networks' first-spike times side by side in slot 0 of the next frame.
module mux_spike_demux #(
   parameter int Q     = 2,
   parameter int GAMMA = 16
) (
   input  logic              clk,
   input  logic              grst,
   mux_spike_demux_if.slave  bus
);
   localparam int            TW   = $clog2(GAMMA);
   localparam logic [TW-1:0] LAST = TW'(GAMMA - 1);

   logic [TW-1:0]                r_cnt;
   logic                         r_slot;
   logic [1:0][Q-1:0][TW-1:0]    r_cap_t;
   logic [1:0][Q-1:0][TW-1:0]    r_rep_t;
   logic [1:0][Q-1:0]            r_seen;
   logic [1:0][Q-1:0]            r_rep_v;
   logic [Q-1:0]                 r_out1;
   logic [Q-1:0]                 r_out2;
   logic                         r_fv;
   logic                         r_serr;

   logic                         w_resync;
   logic [TW-1:0]                w_cnt;
   logic                         w_slot;
   logic                         w_wrap;
   logic                         w_bnd;
   logic [TW-1:0]                w_ncnt;
   logic                         w_nslot;
   logic [1:0][Q-1:0][TW-1:0]    w_cap_t;
   logic [1:0][Q-1:0]            w_seen;
   logic [1:0][Q-1:0][TW-1:0]    w_cap_n;
   logic [1:0][Q-1:0]            w_seen_n;
   logic [1:0][Q-1:0][TW-1:0]    w_rep_t_n;
   logic [1:0][Q-1:0]            w_rep_v_n;
   logic [Q-1:0]                 w_out1;
   logic [Q-1:0]                 w_out2;

   // An off-grid sync turns the current cycle into slot 0 / cycle 0
   always_comb begin
      w_resync = bus.frame_sync && !(r_cnt == '0 && !r_slot);
      w_cnt    = w_resync ? '0 : r_cnt;
      w_slot   = w_resync ? 1'b0 : r_slot;
      w_wrap   = (w_cnt == LAST);
      w_bnd    = w_wrap && w_slot;
      w_ncnt   = w_wrap ? '0 : w_cnt + TW'(1);
      w_nslot  = w_slot ^ w_wrap;

      for (int s = 0; s < 2; s++) begin
         for (int q = 0; q < Q; q++) begin
            w_cap_t[s][q] = w_resync ? '0 : r_cap_t[s][q];
            w_seen[s][q]  = !w_resync && r_seen[s][q];
            if (bus.col_spikes[q] && (w_slot == s[0]) && !w_seen[s][q]) begin
               w_cap_t[s][q] = w_cnt;
               w_seen[s][q]  = 1'b1;
            end
         end
      end

      w_cap_n   = w_cap_t;
      w_seen_n  = w_seen;
      w_rep_t_n = w_resync ? '0 : r_rep_t;
      w_rep_v_n = w_resync ? '0 : r_rep_v;
      if (w_bnd) begin
         w_rep_t_n = w_cap_t;
         w_rep_v_n = w_seen;
         w_cap_n   = '0;
         w_seen_n  = '0;
      end

      // Compare against next cycle's position so outputs leave a flop
      for (int q = 0; q < Q; q++) begin
         w_out1[q] = !w_nslot && w_rep_v_n[0][q] && (w_rep_t_n[0][q] == w_ncnt);
         w_out2[q] = !w_nslot && w_rep_v_n[1][q] && (w_rep_t_n[1][q] == w_ncnt);
      end
   end

   always_ff @(posedge clk) begin
      if (grst) begin
         r_cnt   <= '0;
         r_slot  <= 1'b0;
         r_cap_t <= '0;
         r_rep_t <= '0;
         r_seen  <= '0;
         r_rep_v <= '0;
         r_out1  <= '0;
         r_out2  <= '0;
         r_fv    <= 1'b0;
         r_serr  <= 1'b0;
      end else begin
         r_cnt   <= w_ncnt;
         r_slot  <= w_nslot;
         r_cap_t <= w_cap_n;
         r_rep_t <= w_rep_t_n;
         r_seen  <= w_seen_n;
         r_rep_v <= w_rep_v_n;
         r_out1  <= w_out1;
         r_out2  <= w_out2;
         r_fv    <= w_bnd ? 1'b1 : (w_resync ? 1'b0 : r_fv);
         r_serr  <= w_resync;
      end
   end

   assign bus.output_spikes1 = r_out1;
   assign bus.output_spikes2 = r_out2;
   assign bus.slot           = w_slot;
   assign bus.frame_valid    = r_fv;
   assign bus.sync_err       = r_serr;
endmodule

// File: tb/tb_mux_spike_demux.sv
// Scoreboard bench for mux_spike_demux (Q=2, GAMMA=16): expected replays are
// queued at stimulus time and popped on the cycle they are due.
module tb_mux_spike_demux;
   typedef struct {
      int         at;
      logic [1:0] o1;
      logic [1:0] o2;
   } exp_t;

   logic clk;
   logic grst;
   int   checks;
   int   failures;
   int   t;
   logic fv_m;
   logic se_m;
   logic [1:0][1:0] seen_m;
   exp_t sb[$];

   mux_spike_demux_if #(.Q(2)) bus ();

   mux_spike_demux #(.Q(2), .GAMMA(16)) dut (
      .clk  (clk),
      .grst (grst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] got();
      return {bus.output_spikes1, bus.output_spikes2,
              bus.slot, bus.frame_valid, bus.sync_err};
   endfunction

   function automatic logic [6:0] exp_vec();
      logic [1:0] e1;
      logic [1:0] e2;
      e1 = '0;
      e2 = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == t) begin
            e1 = e1 | sb[i].o1;
            e2 = e2 | sb[i].o2;
            sb.delete(i);
         end
      end
      return {e1, e2, ((t / 16) % 2) == 1, fv_m, se_m};
   endfunction

   task automatic drive(input logic [1:0] col, input logic fs, input logic rst);
      int   s;
      int   c;
      exp_t e;
      logic se_n;
      bus.col_spikes = col;
      bus.frame_sync = fs;
      grst = rst;
      se_n = 1'b0;
      if (rst) begin
         sb.delete();
         seen_m = '0;
         fv_m = 1'b0;
         t = -1;
      end else begin
         if (fs && (t % 32) != 0) begin
            sb.delete();
            seen_m = '0;
            fv_m = 1'b0;
            t = 0;
            se_n = 1'b1;
         end
         s = (t / 16) % 2;
         c = t % 16;
         for (int q = 0; q < 2; q++) begin
            if (col[q] && !seen_m[s][q]) begin
               seen_m[s][q] = 1'b1;
               e.at = t + ((s == 1) ? 16 : 32);
               e.o1 = (s == 0) ? (2'b01 << q) : 2'b00;
               e.o2 = (s == 1) ? (2'b01 << q) : 2'b00;
               sb.push_back(e);
            end
         end
         if (c == 15 && s == 1) begin
            seen_m = '0;
            fv_m = 1'b1;
         end
      end
      se_m = se_n;
      t++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [6:0] g;
      logic [6:0] w;
      for (int i = 0; i < 7; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL reset t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         if (i < 5) drive(2'b00, 1'b0, 1'b0);
         else if (i == 5) drive(2'b00, 1'b1, 1'b1);
      end
   endtask

   task automatic test_basic();
      logic [6:0] g;
      logic [6:0] w;
      logic [1:0] col;
      for (int i = 0; i < 96; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL basic t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         col = (t == 3) ? 2'b01 : (t == 25) ? 2'b10 : 2'b00;
         drive(col, 1'b0, 1'b0);
      end
   endtask

   task automatic test_first_spike();
      logic [6:0] g;
      logic [6:0] w;
      logic [1:0] col;
      int         p;
      for (int i = 0; i < 64; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL first_spike t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         p = t % 32;
         col = (i < 32 && (p == 2 || p == 5 || p == 7 || p == 20 || p == 22))
               ? 2'b01 : 2'b00;
         drive(col, 1'b0, 1'b0);
      end
   endtask

   task automatic test_boundary();
      logic [6:0] g;
      logic [6:0] w;
      logic [1:0] col;
      for (int i = 0; i < 64; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL boundary t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         col = (i == 0) ? 2'b01 : (i == 31) ? 2'b10 : 2'b00;
         drive(col, 1'b0, 1'b0);
      end
   endtask

   task automatic test_silent();
      logic [6:0] g;
      logic [6:0] w;
      for (int i = 0; i < 64; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL silent t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         drive(2'b00, 1'b0, 1'b0);
      end
   endtask

   task automatic test_resync();
      logic [6:0] g;
      logic [6:0] w;
      logic [1:0] col;
      logic       fs;
      logic       done;
      done = 1'b0;
      for (int i = 0; i < 121; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL resync t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         col = 2'b00;
         fs = 1'b0;
         if (!done && t % 32 == 3) col = 2'b01;
         if (done && t == 35) col = 2'b01;
         if (done && (t == 32 || t == 64)) fs = 1'b1;
         if (!done && t % 32 == 20) begin
            col = 2'b10;
            fs = 1'b1;
            done = 1'b1;
         end
         drive(col, fs, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] g;
      logic [6:0] w;
      logic [1:0] col;
      logic       rst;
      logic       done;
      done = 1'b0;
      for (int i = 0; i < 130; i++) begin
         w = exp_vec();
         g = got();
         checks++;
         if (g !== w) begin
            failures++;
            $display("FAIL reset_mid t=%0d o1/o2/slot/fv/serr got=%b want=%b", t, g, w);
         end
         col = 2'b00;
         rst = 1'b0;
         if (!done) begin
            col = (t == 130) ? 2'b11 : (t == 150) ? 2'b10 :
                  (t == 161) ? 2'b01 : 2'b00;
            if (t == 166) begin
               rst = 1'b1;
               done = 1'b1;
            end
         end
         drive(col, 1'b0, rst);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
   endtask

   initial begin
      clk = 1'b0;
      grst = 1'b1;
      bus.frame_sync = 1'b0;
      bus.col_spikes = '0;
      checks = 0;
      failures = 0;
      t = 0;
      fv_m = 1'b0;
      se_m = 1'b0;
      seen_m = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      test_basic();
      test_first_spike();
      test_boundary();
      test_silent();
      test_resync();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
